window_gen: RTL and testbench

Upstream stage of the convolution datapath. Accepts a raster-order pixel stream (one 8-bit pixel per accepted beat, row 0 col 0 first) and produces every fully-interior 3x3 neighbourhood as nine parallel pixels p0..p8, the exact operand set the `sop` multiply-accumulate consumes. Uses two line buffers plus a 3x3 register window, with valid/ready handshakes on both sides, so the convolution no longer needs a random-access 9-port image RAM.

---
 rtl/window_gen_pkg.sv | 27 ++
 rtl/window_gen_if.sv | 42 ++++
 rtl/window_gen_line_buffer.sv | 40 ++++
 rtl/window_gen.sv | 174 +++++++++++++++++
 tb/tb_window_gen.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/window_gen_pkg.sv
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants and types for the convolution front end.
//               PIX_W     - pixel width (fixed at 8)
//               ADDR_W    - row/column counter width
//               IMG_W_DEF - default pixels per row
//               IMG_H_DEF - default rows per frame
//               state_t   - window generator FSM encoding {FILL, RUN}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

  localparam int PIX_W     = 8;
  localparam int ADDR_W    = 16;
  localparam int IMG_W_DEF = 64;
  localparam int IMG_H_DEF = 64;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/window_gen_if.sv
// ============================================================================
// Module      : window_gen_if
// Description : Pixel-stream in / 3x3-window out handshake bundle.
//               in_valid/in_ready/in_pixel     - raster pixel stream
//               out_valid/out_ready            - window handshake
//               p0..p8                         - window, row-major
//               out_row/out_col                - centre coordinates
//               frame_done                     - last-window pulse
//               modport slave  : window generator side
//               modport master : producer/consumer side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface window_gen_if;
  import conv_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PIX_W-1:0]  in_pixel;
  logic              out_valid;
  logic              out_ready;
  logic [PIX_W-1:0]  p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic [ADDR_W-1:0] out_row;
  logic [ADDR_W-1:0] out_col;
  logic              frame_done;

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8,
           out_row, out_col, frame_done
  );

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8,
           out_row, out_col, frame_done
  );

endinterface

`default_nettype wire

// File: rtl/window_gen_line_buffer.sv
// ============================================================================
// Module      : line_buffer
// Description : Single-clock line memory, one read and one write at the same
//               index per cycle. Read is combinational, so the value seen in
//               a cycle is the one stored before that cycle's write.
//               clk     - clock
//               wr_en   - write rd/wr index this cycle
//               addr    - shared read/write index
//               wr_data - data written at the clock edge
//               rd_data - current contents at addr
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buffer #(
  parameter int DEPTH = 64,
  parameter int W     = 16,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  rd_data
);

  // Contents need no reset: the fill phase rewrites every entry before use.
  logic [W-1:0] r_mem [DEPTH];

  assign rd_data = r_mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[addr] <= wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/window_gen.sv
// ============================================================================
// Module      : window_gen
// Description : Turns a raster pixel stream into every fully-interior 3x3
//               neighbourhood, using two line buffers and a 3x3 register
//               window. One output register, no skid buffer.
//               clk - rising-edge clock
//               rst - asynchronous active-low reset
//               bus - window_gen_if.slave (pixel in, window out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic         clk,
  input  logic         rst,
  window_gen_if.slave  bus
);

  localparam int                c_aw       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [ADDR_W-1:0] c_last_col = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] c_last_row = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_two      = ADDR_W'(2);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_row, r_col;
  logic [PIX_W-1:0]  r_win [3][3];   // [row top..bottom][col left..right]

  logic              r_out_valid;
  logic [PIX_W-1:0]  r_p [9];
  logic [ADDR_W-1:0] r_out_row, r_out_col;
  logic              r_frame_done;

  logic              w_in_ready, w_accept, w_emit;
  logic              w_last_col, w_last_pix;
  logic [PIX_W-1:0]  w_lb0, w_lb1;
  logic [2*PIX_W-1:0] w_lb_rd, w_lb_wr;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_last_col = (r_col == c_last_col);
  assign w_last_pix = w_last_col && (r_row == c_last_row);

  // Both line buffers share one memory: upper half is row r-2, lower r-1.
  // Writing {old r-1, new pixel} ages each column down by one row.
  assign {w_lb0, w_lb1} = w_lb_rd;
  assign w_lb_wr        = {w_lb1, bus.in_pixel};

  line_buffer #(
    .DEPTH (IMG_W),
    .W     (2*PIX_W)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (w_accept),
    .addr    (r_col[c_aw-1:0]),
    .wr_data (w_lb_wr),
    .rd_data (w_lb_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    case (r_state)
      FILL: begin
        if (w_accept && (r_row == c_two) && (r_col == '0)) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // Columns 0 and 1 of each row would straddle the row wrap.
        w_emit = w_accept && (r_col >= c_two);
        if (w_accept && w_last_pix) begin
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= (r_row == c_last_row) ? '0 : r_row + c_one;
      end else begin
        r_col <= r_col + c_one;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_win[i][j] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
      end
      r_win[0][2] <= w_lb0;
      r_win[1][2] <= w_lb1;
      r_win[2][2] <= bus.in_pixel;
    end
  end

  // The emitted window is the post-shift window, taken straight from the
  // shift inputs so it lands in the same cycle as the accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_frame_done <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        r_p[k] <= '0;
      end
    end else begin
      r_frame_done <= w_emit && w_last_pix;
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_row   <= r_row - c_one;
        r_out_col   <= r_col - c_one;
        r_p[0]      <= r_win[0][1];
        r_p[1]      <= r_win[0][2];
        r_p[2]      <= w_lb0;
        r_p[3]      <= r_win[1][1];
        r_p[4]      <= r_win[1][2];
        r_p[5]      <= w_lb1;
        r_p[6]      <= r_win[2][1];
        r_p[7]      <= r_win[2][2];
        r_p[8]      <= bus.in_pixel;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_row    = r_out_row;
  assign bus.out_col    = r_out_col;
  assign bus.frame_done = r_frame_done;
  assign bus.p0 = r_p[0];
  assign bus.p1 = r_p[1];
  assign bus.p2 = r_p[2];
  assign bus.p3 = r_p[3];
  assign bus.p4 = r_p[4];
  assign bus.p5 = r_p[5];
  assign bus.p6 = r_p[6];
  assign bus.p7 = r_p[7];
  assign bus.p8 = r_p[8];

endmodule

`default_nettype wire

// File: tb/tb_window_gen.sv
// ============================================================================
// Module      : tb_window_gen
// Description : Directed bench for window_gen. Three instances (4x4, 8x6,
//               3x3) share clock, reset and stimulus; sel routes the stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_window_gen;
  import conv_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tb_valid, tb_ready;
  logic [7:0] tb_pixel;
  int         sel;
  int         checks, failures;

  always #5 clk = ~clk;

  window_gen_if if4 ();
  window_gen_if if86 ();
  window_gen_if if3 ();

  assign if4.in_valid   = tb_valid && (sel == 0);
  assign if86.in_valid  = tb_valid && (sel == 1);
  assign if3.in_valid   = tb_valid && (sel == 2);
  assign if4.in_pixel   = tb_pixel;
  assign if86.in_pixel  = tb_pixel;
  assign if3.in_pixel   = tb_pixel;
  assign if4.out_ready  = tb_ready;
  assign if86.out_ready = tb_ready;
  assign if3.out_ready  = tb_ready;

  window_gen #(.IMG_W(4), .IMG_H(4)) u_dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
  window_gen #(.IMG_W(8), .IMG_H(6)) u_dut86 (.clk(clk), .rst(rst), .bus(if86.slave));
  window_gen #(.IMG_W(3), .IMG_H(3)) u_dut3  (.clk(clk), .rst(rst), .bus(if3.slave));

  logic        m_in_ready, m_out_valid, m_fd;
  logic [71:0] m_p;
  logic [15:0] m_row, m_col;

  always_comb begin
    m_in_ready  = if4.in_ready;
    m_out_valid = if4.out_valid;
    m_fd        = if4.frame_done;
    m_row       = if4.out_row;
    m_col       = if4.out_col;
    m_p = {if4.p0, if4.p1, if4.p2, if4.p3, if4.p4, if4.p5, if4.p6, if4.p7, if4.p8};
    if (sel == 1) begin
      m_in_ready  = if86.in_ready;
      m_out_valid = if86.out_valid;
      m_fd        = if86.frame_done;
      m_row       = if86.out_row;
      m_col       = if86.out_col;
      m_p = {if86.p0, if86.p1, if86.p2, if86.p3, if86.p4, if86.p5, if86.p6, if86.p7, if86.p8};
    end else if (sel == 2) begin
      m_in_ready  = if3.in_ready;
      m_out_valid = if3.out_valid;
      m_fd        = if3.frame_done;
      m_row       = if3.out_row;
      m_col       = if3.out_col;
      m_p = {if3.p0, if3.p1, if3.p2, if3.p3, if3.p4, if3.p5, if3.p6, if3.p7, if3.p8};
    end
  end

  typedef struct packed {
    logic [71:0] p;
    logic [15:0] row;
    logic [15:0] col;
    logic        fd;
  } win_t;

  win_t q[$];
  int   fd_cnt = 0;

  // Record every window at the cycle it is handed over.
  always @(negedge clk) begin
    win_t w;
    if (m_out_valid && tb_ready) begin
      w.p   = m_p;
      w.row = m_row;
      w.col = m_col;
      w.fd  = m_fd;
      q.push_back(w);
    end
    if (m_fd) fd_cnt = fd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected window for centre (rr,cc) of an image whose pixel = base + r*w + c.
  function automatic logic [71:0] mk(input int base, input int w, input int rr, input int cc);
    logic [71:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) begin
      v[71-8*k -: 8] = 8'(base + (rr - 1 + k / 3) * w + (cc - 1 + k % 3));
    end
    return v;
  endfunction

  // Entered and left at posedge+1. Sends pixels first..last of a frame.
  task automatic send(input int base, input int first, input int last, input int gap);
    int  idx;
    int  guard;
    bit  acc;
    idx   = first;
    guard = 0;
    while (idx <= last && guard < 5000) begin
      tb_valid = ($urandom_range(0, 99) >= gap);
      tb_pixel = 8'(base + idx);
      @(negedge clk);
      acc = tb_valid && m_in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      guard++;
    end
    tb_valid = 1'b0;
    chk("send_timeout", 128'(idx > last), 128'(1));
  endtask

  task automatic idle(input int n);
    tb_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input int qb, input int w, input int h, input int base);
    int   idx;
    win_t e;
    idx = qb;
    for (int rr = 1; rr <= h - 2; rr++) begin
      for (int cc = 1; cc <= w - 2; cc++) begin
        e = (idx < q.size()) ? q[idx] : '0;
        chk($sformatf("win%0d_p", idx - qb), 128'(e.p), 128'(mk(base, w, rr, cc)));
        chk($sformatf("win%0d_rc", idx - qb), 128'({e.row, e.col}),
            128'({16'(rr), 16'(cc)}));
        chk($sformatf("win%0d_fd", idx - qb), 128'(e.fd),
            128'((rr == h - 2) && (cc == w - 2)));
        idx++;
      end
    end
  endtask

  localparam logic [71:0] c_first4 = 72'h00_01_02_04_05_06_08_09_0A;
  localparam logic [71:0] c_last4  = 72'h05_06_07_09_0A_0B_0D_0E_0F;
  localparam logic [71:0] c_f2w1   = 72'h64_65_66_68_69_6A_6C_6D_6E;
  localparam logic [71:0] c_win3   = 72'h00_01_02_03_04_05_06_07_08;

  initial begin
    int qb;
    int fb;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    tb_valid = 1'b0;
    tb_ready = 1'b1;
    tb_pixel = '0;
    sel      = 0;

    // Reset state
    #12;
    chk("rst_valid", 128'(m_out_valid), 128'(0));
    chk("rst_p", 128'(m_p), 128'(0));
    chk("rst_rowcol", 128'({m_row, m_col}), 128'(0));
    chk("rst_fd", 128'(m_fd), 128'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 128'(m_in_ready), 128'(1));

    // 4x4 free-running
    qb = q.size(); fb = fd_cnt;
    send(0, 0, 15, 0);
    idle(3);
    chk("c1_count", 128'(q.size() - qb), 128'(4));
    chk("c1_first", 128'(q[qb].p), 128'(c_first4));
    chk("c1_last", 128'(q[qb+3].p), 128'(c_last4));
    check_frame(qb, 4, 4, 0);
    chk("c1_fd_cnt", 128'(fd_cnt - fb), 128'(1));

    // 4x4 with consumer stall after the first window
    qb = q.size(); fb = fd_cnt;
    send(0, 0, 10, 0);
    chk("c2_latency_valid", 128'(m_out_valid), 128'(1));
    tb_ready = 1'b0;
    tb_valid = 1'b1;
    tb_pixel = 8'd11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("c2_hold_in_ready", 128'(m_in_ready), 128'(0));
      chk("c2_hold_valid", 128'(m_out_valid), 128'(1));
      chk("c2_hold_p", 128'(m_p), 128'(c_first4));
      @(posedge clk);
      #1;
    end
    tb_ready = 1'b1;
    send(0, 11, 15, 0);
    idle(3);
    chk("c2_count", 128'(q.size() - qb), 128'(4));
    check_frame(qb, 4, 4, 0);
    chk("c2_fd_cnt", 128'(fd_cnt - fb), 128'(1));

    // 8x6 with 50% input gaps
    sel = 1;
    qb = q.size(); fb = fd_cnt;
    send(0, 0, 47, 50);
    idle(3);
    chk("c3_count", 128'(q.size() - qb), 128'(24));
    check_frame(qb, 8, 6, 0);
    chk("c3_fd_cnt", 128'(fd_cnt - fb), 128'(1));

    // Two back-to-back 4x4 frames
    sel = 0;
    qb = q.size(); fb = fd_cnt;
    send(0, 0, 15, 0);
    send(100, 0, 15, 0);
    idle(3);
    chk("c4_count", 128'(q.size() - qb), 128'(8));
    chk("c4_f2_first", 128'(q[qb+4].p), 128'(c_f2w1));
    check_frame(qb, 4, 4, 0);
    check_frame(qb + 4, 4, 4, 100);
    chk("c4_fd_cnt", 128'(fd_cnt - fb), 128'(2));

    // Reset mid-frame after 9 pixels
    send(0, 0, 8, 0);
    rst = 1'b0;
    #1;
    chk("c5a_valid", 128'(m_out_valid), 128'(0));
    chk("c5a_p", 128'(m_p), 128'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset while a window is on the output
    send(0, 0, 10, 0);
    chk("c5b_pre_valid", 128'(m_out_valid), 128'(1));
    rst = 1'b0;
    #1;
    chk("c5b_valid", 128'(m_out_valid), 128'(0));
    chk("c5b_p", 128'(m_p), 128'(0));
    chk("c5b_rowcol", 128'({m_row, m_col}), 128'(0));
    chk("c5b_fd", 128'(m_fd), 128'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    qb = q.size(); fb = fd_cnt;
    send(0, 0, 15, 0);
    idle(3);
    chk("c5_count", 128'(q.size() - qb), 128'(4));
    check_frame(qb, 4, 4, 0);
    chk("c5_fd_cnt", 128'(fd_cnt - fb), 128'(1));

    // Minimum 3x3 image
    sel = 2;
    qb = q.size(); fb = fd_cnt;
    send(0, 0, 8, 0);
    idle(3);
    chk("c6_count", 128'(q.size() - qb), 128'(1));
    chk("c6_p", 128'(q[qb].p), 128'(c_win3));
    check_frame(qb, 3, 3, 0);
    chk("c6_fd_cnt", 128'(fd_cnt - fb), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
